branch_seq: RTL and testbench

Multi-cycle sequencer for conditional branches (beq/bne/blt/bge/bltu/bgeu) in the core's ALU path. It accepts a B-type instruction and its PC, fetches rs1 then rs2 over the single shared register-file read port, then compares the operands. It returns the next PC, the taken flag and an exception flag to the PC/fetch logic through a valid/ready-in, done-pulse-out handshake. All results leave on registered outputs.

---
 rtl/branch_seq.sv | 166 ++++++++++++++++
 tb/tb_branch_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// Multi-cycle conditional-branch sequencer: reads rs1/rs2 over a shared
// register-file port, compares them, and returns next PC, taken and exception.
module branch_seq #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iVALID,
  output logic            oREADY,
  input  logic [31:0]     iIR,
  input  logic [PC_W-1:0] iPC,
  input  logic            iFLUSH,
  output logic            oRF_REN,
  output logic [4:0]      oRF_RADDR,
  input  logic [XLEN-1:0] iRF_RDATA,
  output logic            oDONE,
  output logic [PC_W-1:0] oPC_NEXT,
  output logic            oTAKEN,
  output logic            oEXC
);

  localparam int unsigned IMM_W = 13;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CMP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [2:0]       func3_q;
  logic [IMM_W-1:0] imm_q;
  logic [PC_W-1:0]  pc_q;
  logic             illegal_q;
  logic [XLEN-1:0]  op1_q;

  logic             accept;
  logic [XLEN-1:0]  op2;
  logic             cond;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  res_pc;
  logic             res_taken;
  logic             res_exc;

  // State register; reset wins over everything.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake / register-file controls.
  always_comb begin
    state_nxt = state;
    oREADY    = 1'b0;
    oRF_REN   = 1'b0;
    oRF_RADDR = 5'd0;
    oDONE     = 1'b0;
    case (state)
      S_IDLE: begin
        oREADY = ~iFLUSH;
        if (iVALID && !iFLUSH) begin
          state_nxt = S_RD1;
        end
      end
      S_RD1: begin
        oRF_REN   = (rs1_q != 5'd0);
        oRF_RADDR = rs1_q;
        state_nxt = iFLUSH ? S_IDLE : S_RD2;
      end
      S_RD2: begin
        oRF_REN   = (rs2_q != 5'd0);
        oRF_RADDR = rs2_q;
        state_nxt = iFLUSH ? S_IDLE : S_CMP;
      end
      S_CMP: begin
        state_nxt = iFLUSH ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        oDONE     = ~iFLUSH & ~iRST;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign accept = (state == S_IDLE) && iVALID && oREADY;

  // Operand-2 selection, comparison and next-PC resolution.
  always_comb begin
    op2    = (rs2_q == 5'd0) ? '0 : iRF_RDATA;
    cond   = 1'b0;
    target = pc_q + PC_W'($signed(imm_q));
    pc_seq = pc_q + PC_W'(3'd4);
    case (func3_q)
      3'd0:    cond = (op1_q == op2);
      3'd1:    cond = (op1_q != op2);
      3'd4:    cond = ($signed(op1_q) <  $signed(op2));
      3'd5:    cond = ($signed(op1_q) >= $signed(op2));
      3'd6:    cond = (op1_q <  op2);
      3'd7:    cond = (op1_q >= op2);
      default: cond = 1'b0;
    endcase
    if (illegal_q) begin
      res_pc    = pc_seq;
      res_taken = 1'b0;
      res_exc   = 1'b1;
    end else if (cond) begin
      res_pc    = target;
      res_taken = 1'b1;
      res_exc   = target[1];
    end else begin
      res_pc    = pc_seq;
      res_taken = 1'b0;
      res_exc   = 1'b0;
    end
  end

  // Instruction capture on accept, op1 capture in RD2, result commit in CMP.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      func3_q   <= 3'd0;
      imm_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      op1_q     <= '0;
      oPC_NEXT  <= '0;
      oTAKEN    <= 1'b0;
      oEXC      <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q     <= iIR[19:15];
        rs2_q     <= iIR[24:20];
        func3_q   <= iIR[14:12];
        imm_q     <= {iIR[31], iIR[7], iIR[30:25], iIR[11:8], 1'b0};
        pc_q      <= iPC;
        illegal_q <= (iIR[6:0] != OPC_BRANCH) ||
                     (iIR[14:12] == 3'd2) || (iIR[14:12] == 3'd3);
      end
      if (state == S_RD2) begin
        op1_q <= (rs1_q == 5'd0) ? '0 : iRF_RDATA;
      end
      if ((state == S_CMP) && !iFLUSH) begin
        oPC_NEXT <= res_pc;
        oTAKEN   <= res_taken;
        oEXC     <= res_exc;
      end
    end
  end

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq with a transaction-level reference model.
module tb_branch_seq;

  localparam int unsigned PC_W = 8;
  localparam int unsigned XLEN = 32;

  logic            iCLK = 1'b0;
  logic            iRST;
  logic            iVALID;
  logic            oREADY;
  logic [31:0]     iIR;
  logic [PC_W-1:0] iPC;
  logic            iFLUSH;
  logic            oRF_REN;
  logic [4:0]      oRF_RADDR;
  logic [XLEN-1:0] iRF_RDATA;
  logic            oDONE;
  logic [PC_W-1:0] oPC_NEXT;
  logic            oTAKEN;
  logic            oEXC;

  branch_seq #(.PC_W(PC_W), .XLEN(XLEN)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iVALID    (iVALID),
    .oREADY    (oREADY),
    .iIR       (iIR),
    .iPC       (iPC),
    .iFLUSH    (iFLUSH),
    .oRF_REN   (oRF_REN),
    .oRF_RADDR (oRF_RADDR),
    .iRF_RDATA (iRF_RDATA),
    .oDONE     (oDONE),
    .oPC_NEXT  (oPC_NEXT),
    .oTAKEN    (oTAKEN),
    .oEXC      (oEXC)
  );

  always #5 iCLK = ~iCLK;

  logic [31:0]     rf [32];
  logic [31:0]     pend_rd = 32'hDEAD;
  int              vectors = 0;
  int              miscompares = 0;

  // Model: age counts cycles since accept (-1 = idle, 1..4 = busy).
  int              age = -1;
  logic [31:0]     m_ir = '0;
  logic [PC_W-1:0] m_pc = '0;
  logic [PC_W-1:0] m_pc_next = '0;
  logic            m_taken = 1'b0;
  logic            m_exc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] btype(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  // Architectural result of one branch, computed from the register file.
  task automatic model_branch(input logic [31:0] ir, input logic [PC_W-1:0] pc,
                              output logic [PC_W-1:0] nxt, output logic tk, output logic ex);
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [12:0] imm;
    int          off;
    logic [PC_W-1:0] tgt;
    logic        cond;
    logic        legal;
    r1  = ir[19:15];
    r2  = ir[24:20];
    f3  = ir[14:12];
    a   = (r1 == 5'd0) ? 32'd0 : rf[r1];
    b   = (r2 == 5'd0) ? 32'd0 : rf[r2];
    imm = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    off = int'($signed(imm));
    tgt = PC_W'(int'(pc) + off);
    legal = (ir[6:0] == 7'b1100011) && (f3 != 3'd2) && (f3 != 3'd3);
    case (f3)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd4:    cond = ($signed(a) < $signed(b));
      3'd5:    cond = ($signed(a) >= $signed(b));
      3'd6:    cond = (a < b);
      3'd7:    cond = (a >= b);
      default: cond = 1'b0;
    endcase
    if (!legal) begin
      nxt = PC_W'(int'(pc) + 4); tk = 1'b0; ex = 1'b1;
    end else if (cond) begin
      nxt = tgt; tk = 1'b1; ex = tgt[1];
    end else begin
      nxt = PC_W'(int'(pc) + 4); tk = 1'b0; ex = 1'b0;
    end
  endtask

  // One clock cycle: respond to reads, drive inputs, check all outputs, advance model.
  task automatic cycle(input logic v, input logic [31:0] ir, input logic [PC_W-1:0] pc,
                       input logic fl, input logic rs);
    logic [PC_W-1:0] n;
    logic t;
    logic e;
    @(negedge iCLK);
    iRF_RDATA = pend_rd;
    pend_rd   = oRF_REN ? rf[oRF_RADDR] : 32'hDEAD;
    iVALID = v; iIR = ir; iPC = pc; iFLUSH = fl; iRST = rs;
    #1;
    chk("ready", 32'(oREADY), 32'((age < 0) && !fl));
    chk("rf_ren", 32'(oRF_REN),
        (age == 1) ? 32'(m_ir[19:15] != 5'd0) : (age == 2) ? 32'(m_ir[24:20] != 5'd0) : 32'd0);
    chk("rf_raddr", 32'(oRF_RADDR),
        (age == 1) ? 32'(m_ir[19:15]) : (age == 2) ? 32'(m_ir[24:20]) : 32'd0);
    chk("done", 32'(oDONE), 32'((age == 4) && !fl && !rs));
    chk("pc_next", 32'(oPC_NEXT), 32'(m_pc_next));
    chk("taken", 32'(oTAKEN), 32'(m_taken));
    chk("exc", 32'(oEXC), 32'(m_exc));
    if (rs) begin
      age = -1; m_pc_next = '0; m_taken = 1'b0; m_exc = 1'b0;
    end else if (age > 0 && fl) begin
      age = -1;
    end else if (age < 0) begin
      if (v && !fl) begin
        age = 1; m_ir = ir; m_pc = pc;
      end
    end else begin
      if (age == 3) begin
        model_branch(m_ir, m_pc, n, t, e);
        m_pc_next = n; m_taken = t; m_exc = e;
      end
      age = (age == 4) ? -1 : age + 1;
    end
  endtask

  // Full branch with junk requests while busy, then literal checks at oDONE.
  task automatic run_branch(input string name, input logic [31:0] ir, input logic [PC_W-1:0] pc,
                            input logic [PC_W-1:0] lpc, input logic lt, input logic le);
    cycle(1'b1, ir, pc, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, $urandom, PC_W'($urandom), 1'b0, 1'b0);
    end
    chk({name, "_done"}, 32'(oDONE), 32'd1);
    chk({name, "_pc"}, 32'(oPC_NEXT), 32'(lpc));
    chk({name, "_taken"}, 32'(oTAKEN), 32'(lt));
    chk({name, "_exc"}, 32'(oEXC), 32'(le));
  endtask

  logic [31:0] ir_bad;

  initial begin
    iRST = 1'b1; iVALID = 1'b0; iFLUSH = 1'b0; iIR = '0; iPC = '0; iRF_RDATA = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
    rf[0] = 32'hDEAD;
    rf[1] = 32'd5;
    rf[2] = 32'd5;
    rf[3] = 32'hFFFF_FFFF;
    rf[4] = 32'd1;
    rf[5] = 32'h8000_0000;
    rf[6] = 32'd0;
    repeat (2) @(posedge iCLK);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    run_branch("beq",      btype(8, 5'd2, 5'd1, 3'd0),   8'h10, 8'h18, 1'b1, 1'b0);
    run_branch("blt",      btype(12, 5'd4, 5'd3, 3'd4),  8'h20, 8'h2C, 1'b1, 1'b0);
    run_branch("bltu",     btype(12, 5'd4, 5'd3, 3'd6),  8'h20, 8'h24, 1'b0, 1'b0);
    run_branch("bgeu",     btype(12, 5'd4, 5'd3, 3'd7),  8'h20, 8'h2C, 1'b1, 1'b0);
    run_branch("bne_wrap", btype(8, 5'd2, 5'd1, 3'd1),   8'hFC, 8'h00, 1'b0, 1'b0);
    run_branch("beq_neg",  btype(-16, 5'd2, 5'd1, 3'd0), 8'h08, 8'hF8, 1'b1, 1'b0);
    run_branch("bge_x0",   btype(8, 5'd5, 5'd0, 3'd5),   8'h30, 8'h38, 1'b1, 1'b0);
    run_branch("x0_dead",  btype(4, 5'd6, 5'd0, 3'd0),   8'h40, 8'h44, 1'b1, 1'b0);
    run_branch("f3_ill",   btype(8, 5'd2, 5'd1, 3'd3),   8'h50, 8'h54, 1'b0, 1'b1);
    run_branch("misalign", btype(6, 5'd2, 5'd1, 3'd0),   8'h60, 8'h66, 1'b1, 1'b1);
    ir_bad = btype(8, 5'd2, 5'd1, 3'd0);
    ir_bad = {ir_bad[31:7], 7'b0110011};
    run_branch("opc_ill",  ir_bad,                       8'h70, 8'h74, 1'b0, 1'b1);

    // Flush in RD2: no done, ready next cycle, outputs unchanged.
    cycle(1'b1, btype(8, 5'd3, 5'd1, 3'd1), 8'h80, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_rd2_ready", 32'(oREADY), 32'd1);
    chk("flush_rd2_pc", 32'(oPC_NEXT), 32'h74);

    // Flush in CMP: results never committed.
    cycle(1'b1, btype(8, 5'd3, 5'd1, 3'd1), 8'h90, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_cmp_pc", 32'(oPC_NEXT), 32'h74);

    // Flush in DONE: pulse suppressed.
    cycle(1'b1, btype(8, 5'd2, 5'd1, 3'd0), 8'hA0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_done_pulse", 32'(oDONE), 32'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Valid together with flush in IDLE is not accepted.
    cycle(1'b1, btype(8, 5'd2, 5'd1, 3'd0), 8'hB0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("vf_idle_ren", 32'(oRF_REN), 32'd0);

    // Reset in CMP drops the branch and clears outputs.
    cycle(1'b1, btype(8, 5'd2, 5'd1, 3'd0), 8'hC0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_ready", 32'(oREADY), 32'd1);
    chk("rst_pc", 32'(oPC_NEXT), 32'd0);
    chk("rst_taken", 32'(oTAKEN), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);

    run_branch("post_rst", btype(-4, 5'd4, 5'd3, 3'd5), 8'hD0, 8'hD4, 1'b0, 1'b0);

    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
